wtm_mac_accum: RTL and testbench



---
 rtl/wtm_mac_accum.sv | 112 +++++++++++
 tb/tb_wtm_mac_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wtm_mac_accum.sv
// Multiply-accumulate stage behind the 5x5 Wallace tree multiplier: sums LEN products
// into one result behind a valid/ready handshake. Define WTM_MAC_SAT_EN for saturation.
module wtm_mac_accum #(
    parameter int PROD_W = 10,
    parameter int ACC_W  = 16,
    parameter int LEN    = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              product_cout,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              out_cout_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               cerr_q, cerr_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;

    logic [ACC_W:0]     sum_full;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   count_inc;
    logic               accept;

    // The extra top bit of sum_full is the carry out of bit ACC_W-1.
    assign sum_full  = {1'b0, acc_q} + (ACC_W+1)'(product);
    assign count_inc = count_q + CNT_W'(1);
`ifdef WTM_MAC_SAT_EN
    assign acc_next  = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    assign acc_next  = sum_full[ACC_W-1:0];
`endif

    assign in_ready     = (state_q != HOLD);
    assign accept       = in_valid && in_ready && !clear;
    assign busy         = (state_q != IDLE);
    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_overflow = ovf_q;
    assign out_cout_err = cerr_q;

    // Priority is clear, then the output handshake, then accepting a beat.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        cerr_d      = cerr_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;

        if (clear || (state_q == HOLD && out_ready)) begin
            state_d     = IDLE;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            cerr_d      = 1'b0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            acc_d   = acc_next;
            count_d = count_inc;
            ovf_d   = ovf_q | sum_full[ACC_W];
            cerr_d  = cerr_q | product_cout;
            if (count_inc == CNT_W'(LEN)) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_sum_d   = acc_next;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            cerr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            cerr_q      <= cerr_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

endmodule

// File: tb/tb_wtm_mac_accum.sv
// Directed testbench for wtm_mac_accum: a table of 4-beat dot products plus
// hand-written sequences for backpressure, clear, overflow and async reset.
module tb_wtm_mac_accum;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [9:0]  product;
    logic        product_cout;
    logic        clear;
    logic        out_ready;

    logic        in_ready, out_valid, out_overflow, out_cout_err, busy;
    logic [15:0] out_sum;

    logic        s_in_ready, s_out_valid, s_out_overflow, s_out_cout_err, s_busy;
    logic [10:0] s_out_sum;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [9:0]  p [4];
        logic [3:0]  c;
        logic [15:0] sum;
        logic        ovf;
        logic        cerr;
    } vec_t;

    vec_t vecs [6];

    wtm_mac_accum #(.PROD_W(10), .ACC_W(16), .LEN(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .product_cout(product_cout), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_cout_err(out_cout_err), .busy(busy)
    );

    // Narrow accumulator so four large products overflow.
    wtm_mac_accum #(.PROD_W(10), .ACC_W(11), .LEN(4), .CNT_W(8)) dut_small (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .product(product), .product_cout(product_cout), .clear(clear),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
        .out_overflow(s_out_overflow), .out_cout_err(s_out_cout_err), .busy(s_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] p, input logic c);
        in_valid     = 1'b1;
        product      = p;
        product_cout = c;
        stepCycle();
        in_valid     = 1'b0;
        product_cout = 1'b0;
    endtask

    task automatic runBeats(input int a, input int b, input int c, input int d);
        applyStimulus(10'(a), 1'b0);
        applyStimulus(10'(b), 1'b0);
        applyStimulus(10'(c), 1'b0);
        applyStimulus(10'(d), 1'b0);
    endtask

    initial begin
        vecs[0] = '{p: '{10'd36, 10'd54, 10'd36, 10'd54}, c: 4'b0000, sum: 16'd180, ovf: 1'b0, cerr: 1'b0};
        vecs[1] = '{p: '{10'd36, 10'd54, 10'd36, 10'd54}, c: 4'b0010, sum: 16'd180, ovf: 1'b0, cerr: 1'b1};
        vecs[2] = '{p: '{10'd10, 10'd20, 10'd30, 10'd40}, c: 4'b0000, sum: 16'd100, ovf: 1'b0, cerr: 1'b0};
        vecs[3] = '{p: '{10'd1023, 10'd1023, 10'd1023, 10'd1023}, c: 4'b0000, sum: 16'd4092, ovf: 1'b0, cerr: 1'b0};
        vecs[4] = '{p: '{10'd0, 10'd0, 10'd0, 10'd0}, c: 4'b1000, sum: 16'd0, ovf: 1'b0, cerr: 1'b1};
        vecs[5] = '{p: '{10'd961, 10'd961, 10'd961, 10'd961}, c: 4'b0000, sum: 16'd3844, ovf: 1'b0, cerr: 1'b0};

        reset        = 1'b1;
        in_valid     = 1'b0;
        product      = '0;
        product_cout = 1'b0;
        clear        = 1'b0;
        out_ready    = 1'b1;
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_sum", 32'(out_sum), 0);
        checkOutput("reset out_overflow", 32'(out_overflow), 0);
        checkOutput("reset out_cout_err", 32'(out_cout_err), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        stepCycle();

        $display("[TB] table vectors, back-to-back with out_ready=1");
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) begin
                applyStimulus(vecs[v].p[i], vecs[v].c[i]);
                if (i < 3) begin
                    checkOutput("accum busy", 32'(busy), 1);
                    checkOutput("accum out_valid", 32'(out_valid), 0);
                end
            end
            checkOutput("result out_valid", 32'(out_valid), 1);
            checkOutput("result out_sum", 32'(out_sum), 32'(vecs[v].sum));
            checkOutput("result out_overflow", 32'(out_overflow), 32'(vecs[v].ovf));
            checkOutput("result out_cout_err", 32'(out_cout_err), 32'(vecs[v].cerr));
            checkOutput("result in_ready", 32'(in_ready), 0);
            stepCycle();
            checkOutput("handoff out_valid", 32'(out_valid), 0);
            checkOutput("handoff in_ready", 32'(in_ready), 1);
            checkOutput("handoff busy", 32'(busy), 0);
            checkOutput("handoff out_sum held", 32'(out_sum), 32'(vecs[v].sum));
            checkOutput("handoff out_cout_err", 32'(out_cout_err), 0);
        end

        $display("[TB] overflow on 11-bit accumulator");
        runBeats(961, 961, 961, 961);
        checkOutput("small out_valid", 32'(s_out_valid), 1);
`ifdef WTM_MAC_SAT_EN
        checkOutput("small out_sum sat", 32'(s_out_sum), 2047);
`else
        checkOutput("small out_sum wrap", 32'(s_out_sum), 1796);
`endif
        checkOutput("small out_overflow", 32'(s_out_overflow), 1);
        checkOutput("wide out_sum", 32'(out_sum), 3844);
        checkOutput("wide out_overflow", 32'(out_overflow), 0);
        stepCycle();
        checkOutput("small overflow cleared", 32'(s_out_overflow), 0);

        $display("[TB] backpressure in HOLD");
        out_ready = 1'b0;
        runBeats(36, 54, 36, 54);
        in_valid = 1'b1;
        product  = 10'd500;
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold out_valid", 32'(out_valid), 1);
            checkOutput("hold out_sum", 32'(out_sum), 180);
            checkOutput("hold in_ready", 32'(in_ready), 0);
            stepCycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepCycle();
        checkOutput("hold handoff out_valid", 32'(out_valid), 0);
        checkOutput("hold handoff busy", 32'(busy), 0);
        runBeats(1, 2, 3, 4);
        checkOutput("post-hold out_sum", 32'(out_sum), 10);
        stepCycle();

        $display("[TB] clear mid-accumulation with idle gap");
        applyStimulus(10'd36, 1'b0);
        applyStimulus(10'd54, 1'b1);
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 10'd99;
        stepCycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clear busy", 32'(busy), 0);
        checkOutput("clear out_cout_err", 32'(out_cout_err), 0);
        checkOutput("clear out_valid", 32'(out_valid), 0);
        applyStimulus(10'd10, 1'b0);
        applyStimulus(10'd20, 1'b0);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("gap busy", 32'(busy), 1);
        checkOutput("gap out_valid", 32'(out_valid), 0);
        applyStimulus(10'd30, 1'b0);
        applyStimulus(10'd40, 1'b0);
        checkOutput("clear out_valid", 32'(out_valid), 1);
        checkOutput("clear out_sum", 32'(out_sum), 100);
        stepCycle();

        $display("[TB] asynchronous reset mid-accumulation");
        applyStimulus(10'd200, 1'b1);
        applyStimulus(10'd300, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async busy", 32'(busy), 0);
        checkOutput("async in_ready", 32'(in_ready), 1);
        checkOutput("async out_sum", 32'(out_sum), 0);
        checkOutput("async out_cout_err", 32'(out_cout_err), 0);
        checkOutput("async out_valid", 32'(out_valid), 0);
        #1;
        reset = 1'b0;
        stepCycle();
        runBeats(36, 54, 36, 54);
        checkOutput("post-reset out_valid", 32'(out_valid), 1);
        checkOutput("post-reset out_sum", 32'(out_sum), 180);
        checkOutput("post-reset out_cout_err", 32'(out_cout_err), 0);
        stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
